// File: rtl/res_pkg.sv
// Shared rename-resource constants and types used by the free list and the ROB.
package res_pkg;

    localparam int unsigned PREG_W    = 6;
    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned NUM_ARCH  = 32;
    localparam int unsigned CNT_W     = 7;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free pregs with an in-list bitmap
// that rejects double frees; up to two allocs and two frees per cycle.
module free_list #(
    parameter int unsigned NUM_PREGS = res_pkg::NUM_PREGS,
    parameter int unsigned NUM_ARCH  = res_pkg::NUM_ARCH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  alloc_num,
    output logic                        alloc_grant,
    output logic [res_pkg::PREG_W-1:0]  alloc_preg_1,
    output logic [res_pkg::PREG_W-1:0]  alloc_preg_2,
    input  logic                        free_valid_1,
    input  logic [res_pkg::PREG_W-1:0]  free_preg_1,
    input  logic                        free_valid_2,
    input  logic [res_pkg::PREG_W-1:0]  free_preg_2,
    output logic [res_pkg::CNT_W-1:0]   free_count,
    output logic                        fl_empty,
    output logic                        fl_err
);

    localparam int unsigned PREG_W = res_pkg::PREG_W;
    localparam int unsigned CNT_W  = res_pkg::CNT_W;

    typedef logic [NUM_PREGS-1:0][PREG_W-1:0] fifo_t;

    // Non-architectural pregs NUM_ARCH.. start out free, in ascending order.
    function automatic fifo_t fifo_init();
        fifo_t f;
        f = '0;
        for (int unsigned i = 0; i < NUM_PREGS - NUM_ARCH; i++) begin
            f[i] = PREG_W'(NUM_ARCH + i);
        end
        return f;
    endfunction

    localparam fifo_t FIFO_RST = fifo_init();
    localparam logic [NUM_PREGS-1:0] IN_LIST_RST =
        {{(NUM_PREGS - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

    fifo_t                  fifo;
    logic [NUM_PREGS-1:0]   in_list;
    logic [NUM_PREGS-1:0]   in_list_d;
    res_pkg::preg_t         head;
    res_pkg::preg_t         tail;
    res_pkg::preg_t         tail_2;
    logic [1:0]             pop_n;
    logic                   req_ok;
    logic                   acc_1;
    logic                   acc_2;
    logic                   drop;

    // Grant and allocated tags come straight off the pre-edge state.
    always_comb begin
        req_ok       = (alloc_num == 2'd1) || (alloc_num == 2'd2);
        alloc_grant  = rst_n && req_ok && (free_count >= CNT_W'(alloc_num));
        alloc_preg_1 = fifo[head];
        alloc_preg_2 = fifo[head + PREG_W'(1)];
        pop_n        = alloc_grant ? alloc_num : 2'd0;
        fl_empty     = (free_count == '0);
    end

    // Slot 2 also loses when it repeats an accepted slot-1 preg.
    always_comb begin
        acc_1  = free_valid_1 && !in_list[free_preg_1];
        acc_2  = free_valid_2 && !in_list[free_preg_2]
                 && !(acc_1 && (free_preg_1 == free_preg_2));
        drop   = (free_valid_1 && !acc_1) || (free_valid_2 && !acc_2);
        tail_2 = tail + PREG_W'(acc_1);
    end

    // Popped and freed pregs never collide: frees need in_list=0, pops have in_list=1.
    always_comb begin
        in_list_d = in_list;
        if (pop_n != 2'd0) in_list_d[alloc_preg_1] = 1'b0;
        if (pop_n == 2'd2) in_list_d[alloc_preg_2] = 1'b0;
        if (acc_1)         in_list_d[free_preg_1]  = 1'b1;
        if (acc_2)         in_list_d[free_preg_2]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo       <= FIFO_RST;
            in_list    <= IN_LIST_RST;
            head       <= '0;
            tail       <= PREG_W'(NUM_PREGS - NUM_ARCH);
            free_count <= CNT_W'(NUM_PREGS - NUM_ARCH);
            fl_err     <= 1'b0;
        end else begin
            if (acc_1) fifo[tail]   <= free_preg_1;
            if (acc_2) fifo[tail_2] <= free_preg_2;
            in_list    <= in_list_d;
            head       <= head + PREG_W'(pop_n);
            tail       <= tail_2 + PREG_W'(acc_2);
            free_count <= free_count - CNT_W'(pop_n) + CNT_W'(acc_1) + CNT_W'(acc_2);
            if ((alloc_num == 2'd3) || drop) fl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Free-list bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] alloc_num = 2'd0;
    logic       alloc_grant;
    logic [5:0] alloc_preg_1, alloc_preg_2;
    logic       free_valid_1 = 1'b0, free_valid_2 = 1'b0;
    logic [5:0] free_preg_1 = 6'd0, free_preg_2 = 6'd0;
    logic [6:0] free_count;
    logic       fl_empty, fl_err;

    free_list dut (
        .clk(clk), .rst_n(rst_n), .alloc_num(alloc_num), .alloc_grant(alloc_grant),
        .alloc_preg_1(alloc_preg_1), .alloc_preg_2(alloc_preg_2),
        .free_valid_1(free_valid_1), .free_preg_1(free_preg_1),
        .free_valid_2(free_valid_2), .free_preg_2(free_preg_2),
        .free_count(free_count), .fl_empty(fl_empty), .fl_err(fl_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: free pregs in FIFO order, membership map, sticky error.
    int mq[$];
    bit mlist[64];
    bit merr;

    bit         exp_grant;
    int         exp_p1, exp_p2;
    logic       obs_grant;
    logic [5:0] obs_p1, obs_p2, obs_head;
    logic [6:0] obs_cnt;
    logic       obs_empty, obs_err;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < 64; i++) mlist[i] = (i >= 32);
        for (int i = 32; i < 64; i++) mq.push_back(i);
        merr = 1'b0;
    endfunction

    function automatic void model_free(input int p);
        if (mlist[p]) merr = 1'b1;
        else begin
            mq.push_back(p);
            mlist[p] = 1'b1;
        end
    endfunction

    // One clock: drive, sample combinational outputs mid-cycle, advance model, sample registers.
    task automatic cyc(input int an, input bit v1, input int p1, input bit v2, input int p2,
                       input bit rst);
        int p;
        alloc_num    = 2'(an);
        free_valid_1 = v1;
        free_preg_1  = 6'(p1);
        free_valid_2 = v2;
        free_preg_2  = 6'(p2);
        rst_n        = rst;
        exp_grant = rst && (an == 1 || an == 2) && (mq.size() >= an);
        exp_p1    = (mq.size() > 0) ? mq[0] : -1;
        exp_p2    = (mq.size() > 1) ? mq[1] : -1;
        @(negedge clk);
        obs_grant = alloc_grant;
        obs_p1    = alloc_preg_1;
        obs_p2    = alloc_preg_2;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else begin
            if (an == 3) merr = 1'b1;
            if (v1) model_free(p1);
            if (v2) model_free(p2);
            if (exp_grant) begin
                repeat (an) begin
                    p = mq.pop_front();
                    mlist[p] = 1'b0;
                end
            end
        end
        obs_cnt   = free_count;
        obs_empty = fl_empty;
        obs_err   = fl_err;
        obs_head  = alloc_preg_1;
    endtask

    function automatic int pick_free_preg();
        if ($urandom_range(9) == 0) return int'($urandom_range(63));
        for (int k = 0; k < 16; k++) begin
            int p = int'($urandom_range(63));
            if (!mlist[p]) return p;
        end
        return int'($urandom_range(63));
    endfunction

    task automatic test_reset();
        cyc(2, 0, 0, 0, 0, 0);
        n_cmp++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", obs_grant); end
        n_cmp++; if (obs_cnt !== 7'd32) begin n_fail++; $display("FAIL reset_count: got %0d want 32", obs_cnt); end
        n_cmp++; if (obs_empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %b want 0", obs_empty); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", obs_err); end
        n_cmp++; if (obs_head !== 6'd32) begin n_fail++; $display("FAIL reset_head: got %0d want 32", obs_head); end
    endtask

    task automatic test_alloc_basic();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0, 1);
        n_cmp++; if (obs_grant !== 1'b1) begin n_fail++; $display("FAIL basic_grant: got %b want 1", obs_grant); end
        n_cmp++; if (obs_p1 !== 6'd32) begin n_fail++; $display("FAIL basic_preg1: got %0d want 32", obs_p1); end
        n_cmp++; if (obs_p2 !== 6'd33) begin n_fail++; $display("FAIL basic_preg2: got %0d want 33", obs_p2); end
        n_cmp++; if (obs_cnt !== 7'd30) begin n_fail++; $display("FAIL basic_count: got %0d want 30", obs_cnt); end
    endtask

    task automatic test_drain();
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(2, 0, 0, 0, 0, 1);
            n_cmp++; if (obs_grant !== 1'b1 || obs_p1 !== 6'(32 + 2 * i)) begin
                n_fail++; $display("FAIL drain_step%0d: got grant=%b preg=%0d want 1/%0d", i, obs_grant, obs_p1, 32 + 2 * i);
            end
        end
        n_cmp++; if (obs_cnt !== 7'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", obs_cnt); end
        n_cmp++; if (obs_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", obs_empty); end
        cyc(1, 0, 0, 0, 0, 1);
        n_cmp++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL empty_grant: got %b want 0", obs_grant); end
        n_cmp++; if (obs_cnt !== 7'd0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", obs_cnt); end
    endtask

    task automatic test_last_one();
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(2, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        n_cmp++; if (obs_cnt !== 7'd1) begin n_fail++; $display("FAIL last_count1: got %0d want 1", obs_cnt); end
        cyc(2, 1, 5, 0, 0, 1);
        n_cmp++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL last_nogrant: got %b want 0", obs_grant); end
        n_cmp++; if (obs_cnt !== 7'd2) begin n_fail++; $display("FAIL last_count2: got %0d want 2", obs_cnt); end
        cyc(2, 0, 0, 0, 0, 1);
        n_cmp++; if (obs_grant !== 1'b1) begin n_fail++; $display("FAIL last_grant: got %b want 1", obs_grant); end
        n_cmp++; if (obs_p1 !== 6'd63) begin n_fail++; $display("FAIL last_preg1: got %0d want 63", obs_p1); end
        n_cmp++; if (obs_p2 !== 6'd5) begin n_fail++; $display("FAIL last_preg2: got %0d want 5", obs_p2); end
        n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL last_err: got %b want 0", obs_err); end
    endtask

    task automatic test_bad_frees();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 7, 1, 7, 1);
        n_cmp++; if (obs_cnt !== 7'd33) begin n_fail++; $display("FAIL dupfree_count: got %0d want 33", obs_cnt); end
        n_cmp++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL dupfree_err: got %b want 1", obs_err); end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 40, 0, 0, 1);
        n_cmp++; if (obs_cnt !== 7'd32) begin n_fail++; $display("FAIL listed_count: got %0d want 32", obs_cnt); end
        n_cmp++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL listed_err: got %b want 1", obs_err); end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(3, 0, 0, 0, 0, 1);
        n_cmp++; if (obs_grant !== 1'b0) begin n_fail++; $display("FAIL num3_grant: got %b want 0", obs_grant); end
        n_cmp++; if (obs_cnt !== 7'd32) begin n_fail++; $display("FAIL num3_count: got %0d want 32", obs_cnt); end
        n_cmp++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL num3_err: got %b want 1", obs_err); end
    endtask

    task automatic test_random_wrap();
        int an, p1, p2;
        bit v1, v2, rst;
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            an  = ($urandom_range(39) == 0) ? 3 : int'($urandom_range(2));
            v1  = $urandom_range(1) == 1;
            v2  = $urandom_range(1) == 1;
            p1  = pick_free_preg();
            p2  = pick_free_preg();
            rst = (i != 200);
            cyc(an, v1, p1, v2, p2, rst);
            n_cmp++; if (obs_grant !== exp_grant) begin
                n_fail++; $display("FAIL rand%0d_grant: got %b want %b", i, obs_grant, exp_grant);
            end
            if (exp_grant) begin
                n_cmp++; if (obs_p1 !== 6'(exp_p1)) begin
                    n_fail++; $display("FAIL rand%0d_preg1: got %0d want %0d", i, obs_p1, exp_p1);
                end
                if (an == 2) begin
                    n_cmp++; if (obs_p2 !== 6'(exp_p2)) begin
                        n_fail++; $display("FAIL rand%0d_preg2: got %0d want %0d", i, obs_p2, exp_p2);
                    end
                end
            end
            n_cmp++; if (obs_cnt !== 7'(mq.size()) || obs_empty !== (mq.size() == 0)) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d/%b want %0d", i, obs_cnt, obs_empty, mq.size());
            end
            n_cmp++; if (obs_err !== merr) begin
                n_fail++; $display("FAIL rand%0d_err: got %b want %b", i, obs_err, merr);
            end
            if (!rst) begin
                n_cmp++; if (obs_head !== 6'd32 || obs_cnt !== 7'd32 || obs_err !== 1'b0) begin
                    n_fail++; $display("FAIL midreset_state: got head=%0d cnt=%0d err=%b want 32/32/0", obs_head, obs_cnt, obs_err);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alloc_basic();
        test_drain();
        test_last_one();
        test_bad_frees();
        test_random_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, physical register count (6-bit preg tag).
REQ-002 SHALL have parameter NUM_ARCH, default 32, architectural register count; p0..p(NUM_ARCH-1) are mapped at reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port alloc_num  input  2  rename request count this cycle: 0, 1 or 2; 3 is illegal.
REQ-006 SHALL have port alloc_grant  output  1  request accepted this cycle.
REQ-007 SHALL have port alloc_preg_1  output  6  first allocated preg, valid when alloc_grant=1.
REQ-008 SHALL have port alloc_preg_2  output  6  second allocated preg, valid when alloc_grant=1 and alloc_num=2.
REQ-009 SHALL have port free_valid_1, free_valid_2  input  1 each  ROB retire-slot frees, slot 1 older.
REQ-010 SHALL have port free_preg_1, free_preg_2  input  6 each  old destination preg released by the retiring instruction.
REQ-011 SHALL have port free_count  output  7  registered number of free pregs, 0..64.
REQ-012 SHALL have port fl_empty  output  1  free_count==0.
REQ-013 SHALL have port fl_err  output  1  sticky error flag.

Function
REQ-014 SHALL hold free pregs in a 64-entry circular FIFO with 6-bit head/tail pointers wrapping modulo 64, plus a 64-bit in_list bitmap.
REQ-015 SHALL drive alloc_grant combinationally = rst_n & (alloc_num==1|alloc_num==2) & (free_count>=alloc_num).
REQ-016 SHALL drive alloc_preg_1=fifo[head] and alloc_preg_2=fifo[head+1 mod 64] combinationally (zero-cycle grant latency).
REQ-017 SHALL, on a posedge with alloc_grant=1, advance head by alloc_num and clear in_list for the popped pregs.
REQ-018 SHALL be all-or-nothing: alloc_num=2 with free_count=1 gives alloc_grant=0 and no pop.
REQ-019 SHALL treat alloc_num=3 as no request: alloc_grant=0, no pop, fl_err set.
REQ-020 SHALL accept a free only if its in_list bit is 0; accepted frees are written at tail, slot 1 before slot 2, tail advanced by the number accepted, in_list bit set.
REQ-021 SHALL drop a free whose preg is already in the list (double free) and set fl_err; the remaining slot packs to tail.
REQ-022 SHALL treat free_valid_1=free_valid_2=1 with equal pregs as one accepted free plus one dropped duplicate (fl_err set).
REQ-023 SHALL make freed pregs allocatable no earlier than the cycle after their free (no same-cycle bypass); grant is decided on the pre-edge free_count.
REQ-024 SHALL update free_count = free_count - popped + accepted each cycle; simultaneous alloc and free in one cycle is legal.
REQ-025 SHALL never overflow: the bitmap bounds free_count at 64.

Reset
REQ-026 SHALL, on posedge clk with rst_n=0, load fifo[i]=NUM_ARCH+i for i=0..31, head=0, tail=32, free_count=32, in_list[63:32]=1, in_list[31:0]=0, fl_err=0.
REQ-027 SHALL hold alloc_grant=0 while rst_n=0; fl_empty=0 after reset.
REQ-028 SHALL discard all state on reset mid-operation; the allocs and frees of that cycle are ignored.

Structure
REQ-029 SHALL take PREG_W=6, NUM_PREGS=64, NUM_ARCH=32 from the shared respackage, which is also used by the ROB.
REQ-030 SHALL be a single module with no sub-module; the FIFO and bitmap are inline.

Verification
REQ-031 Reset, then alloc_num=2 -> alloc_grant=1, pregs 32,33; next cycle free_count=30.
REQ-032 Issue 16 cycles of alloc_num=2 from reset -> free_count=0, fl_empty=1; alloc_num=1 -> alloc_grant=0.
REQ-033 At free_count=1, alloc_num=2 with free_valid_1=1, free_preg_1=5 -> alloc_grant=0 that cycle; next cycle free_count=2, and alloc_num=2 is granted with the remaining preg and then 5.
REQ-034 free_valid_1=free_valid_2=1, free_preg_1=free_preg_2=7 (7 not in list) -> free_count+1, fl_err=1.
REQ-035 Free p40 right after reset (p40 already in list) -> dropped, free_count stays 32, fl_err=1.
REQ-036 Run 64+ alloc/free cycles across the pointer wrap -> pregs are returned in FIFO order with no loss; assert rst_n=0 mid-stream -> reset state of REQ-026.
